// File: rtl/pipe_tx_block_scheduler_if.sv
// Transmit-side bundle between the OS/data requesters and the block scheduler,
// plus the scheduler's scrambler-facing outputs.
interface pipe_tx_block_scheduler_if;
    logic        os_valid;
    logic [31:0] os_data;
    logic [3:0]  os_k;
    logic        os_ready;
    logic        data_valid;
    logic [31:0] data_in;
    logic [3:0]  data_k;
    logic        data_ready;
    logic [31:0] sch_data;
    logic [3:0]  sch_k;
    logic [1:0]  sch_sync_header;
    logic        sch_valid;
    logic        skp_inserted;
    logic        data_underrun;

    modport master (
        output os_valid, os_data, os_k, data_valid, data_in, data_k,
        input  os_ready, data_ready, sch_data, sch_k, sch_sync_header,
               sch_valid, skp_inserted, data_underrun
    );

    modport slave (
        input  os_valid, os_data, os_k, data_valid, data_in, data_k,
        output os_ready, data_ready, sch_data, sch_k, sch_sync_header,
               sch_valid, skp_inserted, data_underrun
    );
endinterface

// File: rtl/pipe_tx_block_scheduler.sv
// Block-boundary arbiter for the PIPE TX path (SKP / OS / DATA / IDL), gen1 and gen5.
// Define SKP_SCHED_EN to build in the internal SKP scheduler and its block counter.
module pipe_tx_block_scheduler #(
    parameter int unsigned BEATS_PER_BLOCK = 4,
    parameter int unsigned SKP_INTERVAL    = 370,
    parameter int unsigned CNT_W           = 12
) (
    input  logic                      pclk,
    input  logic                      reset_n,
    input  logic [2:0]                generation,
    pipe_tx_block_scheduler_if.slave  bus
);
    localparam int unsigned BW        = (BEATS_PER_BLOCK > 1) ? $clog2(BEATS_PER_BLOCK) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS_PER_BLOCK - 1);

    if (SKP_INTERVAL < 2 || SKP_INTERVAL > 4095 || SKP_INTERVAL > (1 << CNT_W)) begin : g_bad_interval
        $error("pipe_tx_block_scheduler: SKP_INTERVAL out of range for CNT_W");
    end

    typedef enum logic [2:0] {GR_NONE, GR_SKP, GR_OS, GR_DATA, GR_IDL} grant_t;

    logic [BW-1:0] r_beat_cnt;
    grant_t        r_grant;
    logic          r_gen5;
    logic [31:0]   r_sch_data;
    logic [3:0]    r_sch_k;
    logic [1:0]    r_sch_sync;
    logic          r_sch_valid;
    logic          r_underrun;

    logic          w_boundary;
    logic          w_gen_ok;
    logic          w_gen5;
    logic          w_skp_due;
    grant_t        w_grant;
    logic [31:0]   w_data;
    logic [3:0]    w_k;
    logic [1:0]    w_sync;
    logic          w_pad;

`ifdef SKP_SCHED_EN
    localparam logic [CNT_W-1:0] SKP_ARM = CNT_W'(SKP_INTERVAL - 2);
    logic [CNT_W-1:0] r_skp_cnt;
    logic             r_skp_pending;
    logic             r_skp_inserted;
    assign w_skp_due        = r_skp_pending;
    assign bus.skp_inserted = r_skp_inserted;
`else
    assign w_skp_due        = 1'b0;
    assign bus.skp_inserted = 1'b0;
`endif

    assign w_boundary = (r_beat_cnt == '0);
    assign w_gen_ok   = (generation == 3'd1) || (generation == 3'd5);
    // Generation only matters at a boundary; mid-block the latched value rules.
    assign w_gen5     = w_boundary ? (generation == 3'd5) : r_gen5;

    always_comb begin
        w_grant = r_grant;
        if (w_boundary) begin
            if (!w_gen_ok)           w_grant = GR_NONE;
            else if (w_skp_due)      w_grant = GR_SKP;
            else if (bus.os_valid)   w_grant = GR_OS;
            else if (bus.data_valid) w_grant = GR_DATA;
            else                     w_grant = GR_IDL;
        end
    end

    assign bus.os_ready   = (w_grant == GR_OS)   && bus.os_valid;
    assign bus.data_ready = (w_grant == GR_DATA) && bus.data_valid;

    always_comb begin
        w_data = '0;
        w_k    = '0;
        w_pad  = 1'b0;
        w_sync = 2'b00;
        case (w_grant)
            GR_SKP: begin
                if (w_gen5) begin
                    w_data = (r_beat_cnt == LAST_BEAT) ? 32'h0000_00E1 : 32'h9999_9999;
                end else begin
                    w_data = w_boundary ? 32'h0000_00BC : 32'h0000_001C;
                    w_k    = 4'b0001;
                end
            end
            GR_OS: begin
                if (bus.os_valid) begin
                    w_data = bus.os_data;
                    w_k    = bus.os_k;
                end else begin
                    w_pad  = 1'b1;
                end
            end
            GR_DATA: begin
                if (bus.data_valid) begin
                    w_data = bus.data_in;
                    w_k    = bus.data_k;
                end else begin
                    w_pad  = 1'b1;
                end
            end
            default: ;
        endcase
        if (!w_gen5) begin
            w_data = {24'h0, w_data[7:0]};
            w_k    = {3'b000, w_k[0]};
        end
        if (w_boundary && w_gen5) begin
            case (w_grant)
                GR_SKP, GR_OS:   w_sync = 2'b01;
                GR_DATA, GR_IDL: w_sync = 2'b10;
                default:         w_sync = 2'b00;
            endcase
        end
    end

    always_ff @(posedge pclk) begin
        if (!reset_n) begin
            r_beat_cnt  <= '0;
            r_grant     <= GR_NONE;
            r_gen5      <= 1'b0;
            r_sch_data  <= '0;
            r_sch_k     <= '0;
            r_sch_sync  <= '0;
            r_sch_valid <= 1'b0;
            r_underrun  <= 1'b0;
`ifdef SKP_SCHED_EN
            r_skp_cnt      <= '0;
            r_skp_pending  <= 1'b0;
            r_skp_inserted <= 1'b0;
`endif
        end else begin
            r_grant     <= w_grant;
            r_sch_data  <= w_data;
            r_sch_k     <= w_k;
            r_sch_sync  <= w_sync;
            r_sch_valid <= (w_grant != GR_NONE);
            r_underrun  <= w_pad;
            if (w_boundary) begin
                r_gen5 <= (generation == 3'd5);
            end
            // An unsupported generation parks the counter on the boundary.
            if (w_grant != GR_NONE) begin
                r_beat_cnt <= (r_beat_cnt == LAST_BEAT) ? '0 : r_beat_cnt + 1'b1;
            end
`ifdef SKP_SCHED_EN
            r_skp_inserted <= w_boundary && (w_grant == GR_SKP);
            if (w_boundary && (w_grant == GR_SKP)) begin
                r_skp_cnt     <= '0;
                r_skp_pending <= 1'b0;
            end else if ((r_beat_cnt == LAST_BEAT) && (w_grant != GR_NONE) &&
                         (w_grant != GR_SKP) && !r_skp_pending) begin
                r_skp_cnt <= r_skp_cnt + 1'b1;
                if (r_skp_cnt == SKP_ARM) begin
                    r_skp_pending <= 1'b1;
                end
            end
`endif
        end
    end

    assign bus.sch_data        = r_sch_data;
    assign bus.sch_k           = r_sch_k;
    assign bus.sch_sync_header = r_sch_sync;
    assign bus.sch_valid       = r_sch_valid;
    assign bus.data_underrun   = r_underrun;
endmodule

// File: doc/pipe_tx_block_scheduler.md
Name: pipe_tx_block_scheduler

Overview:
- Sequences the PIPE transmit datapath ahead of the scrambler and PIPE data stage.
- Shares the 32-bit scrambler input between three sources: the internal SKP generator, an ordered-set (OS) requester and a data/framing requester.
- Arbitration happens only on 4-beat block boundaries. The block emits per-beat data, K flags and sync header. Sync header is nonzero on beat 0 only, which is what downstream start-of-block detection uses.
- Supports generation 1 (8-bit, 8b/10b K symbols) and generation 5 (32-bit, 128b/130b).

Parameters:
- BEATS_PER_BLOCK, 4, beats per arbitration block (gen5 block = 16 bytes at 32 bits; gen1 OS = 4 symbols).
- SKP_INTERVAL, 370, completed blocks between SKP insertions; legal range 2..4095.
- CNT_W, 12, width of the SKP block counter.

Ports:
- pclk  input  1  PIPE clock
- reset_n  input  1  synchronous, active-low reset
- generation  input  3  1 = gen1, 5 = gen5, others unsupported
- os_valid  input  1  OS requester has a beat
- os_data  input  32  OS beat
- os_k  input  4  OS K flags (gen1 uses bit 0)
- os_ready  output  1  OS beat consumed this cycle
- data_valid  input  1  data requester has a beat
- data_in  input  32  data beat
- data_k  input  4  data K flags
- data_ready  output  1  data beat consumed this cycle
- sch_data  output  32  to scramblerDataOut
- sch_k  output  4  to scramblerDataK
- sch_sync_header  output  2  to scramblerSyncHeader
- sch_valid  output  1  to scramblerDataValid
- skp_inserted  output  1  one-cycle pulse with SKP beat 0
- data_underrun  output  1  one-cycle pulse when a granted beat is padded

Behaviour:
- Reset (pclk edge with reset_n=0): all outputs 0, beat_cnt=0, grant=NONE, skp_cnt=0, skp_pending=0. A reset mid-block abandons the block immediately; no completion is owed.
- beat_cnt counts 0..BEATS_PER_BLOCK-1 and wraps. It advances every cycle while generation is supported.
- Grant encoding: NONE, SKP, OS, DATA, IDL. The grant is decided combinationally at beat_cnt==0 and registered for beats 1..3.
- Priority at beat 0: skp_pending > os_valid > data_valid > IDL.
- Ready signals:
  - os_ready = grant/decision is OS and os_valid. Same rule for data_ready with DATA.
  - Both are 0 outside their grant and never both 1.
- Latency: a beat accepted (valid&ready) in cycle N appears on sch_* in cycle N+1. All sch_* outputs are registered.
- Padding: if the granted source has valid=0 on beats 1..3, output data=0, k=0, and pulse data_underrun. The block is still completed and the grant is kept.
- Sync header (gen5): beat 0 carries 2'b01 for SKP/OS or 2'b10 for DATA/IDL. Beats 1..3 carry 2'b00. In gen1 sync header is always 2'b00.
- Width: gen1 drives bits [7:0] and k[0] only; upper bits are 0. Gen5 drives all 32/4 bits.
- SKP content:
  - gen5: beats 0-2 = 32'h9999_9999, k=0; beat 3 = 32'h0000_00E1, k=0.
  - gen1: beat 0 = 8'hBC, k=1 (COM); beats 1-3 = 8'h1C, k=1.
- IDL content: data 0, k 0, sch_valid=1.
- SKP counter:
  - skp_cnt increments on each completed non-SKP block (beat 3).
  - At SKP_INTERVAL-1 it sets skp_pending and holds.
  - An SKP grant clears skp_pending and skp_cnt.
  - A pending SKP waits for the next boundary and never preempts a block in progress.
- Generation change: generation is sampled only at beat 0.
- Unsupported generation at beat 0: grant=NONE, sch_valid=0, all sch_* and ready outputs 0, beat_cnt held at 0, skp_cnt held.
- A generation change mid-block takes effect at the next boundary.

Optional Feature:
- SKP_SCHED_EN defined: the internal SKP scheduler and counter are present, as above.
- SKP_SCHED_EN undefined: no counter and no SKP grant; skp_inserted is tied 0; priority is OS > DATA > IDL. SKP must then be supplied by the OS requester.

Test Plan:
- Gen5, data_valid=1 continuously with data_in=32'hA0A0_0001 incrementing, no OS -> sch_sync_header=2'b10 on every 4th beat and 00 otherwise; sch_data mirrors data_in one cycle later; data_ready=1 every cycle.
- Gen5, OS and data both valid at a boundary -> OS wins; 4 OS beats with sync 2'b01 on beat 0; data_ready=0 for those 4 cycles; data resumes at the next boundary.
- Gen5, SKP_INTERVAL=4, data always valid -> after 3 data blocks, an SKP block (9999_9999 x3, 0000_00E1) with skp_inserted on beat 0; period = 4 blocks.
- Gen1, no requests -> IDL: sch_valid=1, sch_data=0. With SKP due -> BC(K), 1C(K) x3 on bits [7:0]; sync header stays 00.
- Data granted, data_valid drops on beat 2 -> beat 2 output 0, data_underrun pulses once, block still 4 beats, next beat 0 re-arbitrates.
- reset_n low on beat 2 of an OS block -> next cycle all outputs 0. Set generation=3 after release -> sch_valid stays 0 and both readies stay 0.
